// File: rtl/frame_window_monitor_if.sv
// Frame handshake bundle between the upstream window sequencer (master) and the monitor (slave).
// FWM_STICKY_EN adds the sticky-error clear/status pair.
interface frame_window_monitor_if #(
  parameter int LEN_W = 4,
  parameter int CNT_W = 16
);
  logic             win_in;
  logic             tog_in;
  logic             frame_done;
  logic [CNT_W-1:0] frame_cnt;
  logic [LEN_W-1:0] len_last;
  logic             err_pulse;
  logic [2:0]       err_code;
`ifdef FWM_STICKY_EN
  logic             err_clr;
  logic [4:0]       err_sticky;

  modport master (
    output win_in, tog_in, err_clr,
    input  frame_done, frame_cnt, len_last, err_pulse, err_code, err_sticky
  );
  modport slave (
    input  win_in, tog_in, err_clr,
    output frame_done, frame_cnt, len_last, err_pulse, err_code, err_sticky
  );
`else
  modport master (
    output win_in, tog_in,
    input  frame_done, frame_cnt, len_last, err_pulse, err_code
  );
  modport slave (
    input  win_in, tog_in,
    output frame_done, frame_cnt, len_last, err_pulse, err_code
  );
`endif
endinterface

// File: rtl/frame_window_monitor.sv
// Passive checker of window length and frame-end toggle alignment; counts good frames.
// Optional FWM_STICKY_EN adds a per-cause sticky error register with software clear.
module frame_window_monitor #(
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 16,
  parameter int MIN_LEN = 7,
  parameter int MAX_LEN = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  frame_window_monitor_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, OPEN, HANG} state_e;

  localparam logic [LEN_W-1:0] LEN_SAT = '1;
  localparam logic [LEN_W:0]   MIN_L   = (LEN_W+1)'(MIN_LEN);
  localparam logic [LEN_W:0]   MAX_L   = (LEN_W+1)'(MAX_LEN);
  localparam logic [2:0] E_SHORT = 3'd1, E_LONG = 3'd2, E_NOTOG = 3'd3,
                         E_ORPH  = 3'd4, E_EARLY = 3'd5;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_cnt_q, len_cnt_d;
  logic [LEN_W-1:0] len_last_q, len_last_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             frame_done_q, frame_done_d;
  logic             err_pulse_q, err_pulse_d;
  logic [2:0]       err_code_q, err_code_d;
  logic             win_dly_q, tog_dly_q, primed_q;

  logic             rise, tog;
  logic             err_set;
  logic [2:0]       err_sel;
  logic [LEN_W:0]   len_inc;
  logic [LEN_W-1:0] len_sat;

  // Edges are suppressed until the first post-reset sample has been captured.
  assign rise    = primed_q & bus.win_in & ~win_dly_q;
  assign tog     = primed_q & (bus.tog_in ^ tog_dly_q);
  assign len_inc = {1'b0, len_cnt_q} + 1'b1;
  assign len_sat = (len_cnt_q == LEN_SAT) ? LEN_SAT : len_inc[LEN_W-1:0];

  always_comb begin
    state_d      = state_q;
    len_cnt_d    = len_cnt_q;
    len_last_d   = len_last_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    err_set      = 1'b0;
    err_sel      = 3'd0;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d   = OPEN;
          len_cnt_d = {{(LEN_W-1){1'b0}}, 1'b1};
          // A toggle on the opening sample is already inside the window.
          if (tog) begin
            err_set = 1'b1;
            err_sel = E_EARLY;
          end
        end else if (tog) begin
          err_set = 1'b1;
          err_sel = E_ORPH;
        end
      end
      OPEN: begin
        if (!bus.win_in) begin
          len_last_d = len_cnt_q;
          state_d    = IDLE;
          if (!tog) begin
            err_set = 1'b1;
            err_sel = E_NOTOG;
          end else if ({1'b0, len_cnt_q} < MIN_L) begin
            err_set = 1'b1;
            err_sel = E_SHORT;
          end else begin
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 1'b1;
          end
        end else begin
          len_cnt_d = len_sat;
          // Overlength outranks a coincident early toggle.
          if (len_inc > MAX_L) begin
            err_set = 1'b1;
            err_sel = E_LONG;
            state_d = HANG;
          end else if (tog) begin
            err_set = 1'b1;
            err_sel = E_EARLY;
          end
        end
      end
      HANG: begin
        if (!bus.win_in) begin
          len_last_d = len_cnt_q;
          state_d    = IDLE;
        end else begin
          len_cnt_d = len_sat;
        end
      end
      default: state_d = IDLE;
    endcase
    err_pulse_d = err_set;
    err_code_d  = err_set ? err_sel : err_code_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      len_cnt_q    <= '0;
      len_last_q   <= '0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_code_q   <= 3'd0;
      win_dly_q    <= 1'b0;
      tog_dly_q    <= 1'b0;
      primed_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_cnt_q    <= len_cnt_d;
      len_last_q   <= len_last_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
      err_pulse_q  <= err_pulse_d;
      err_code_q   <= err_code_d;
      win_dly_q    <= bus.win_in;
      tog_dly_q    <= bus.tog_in;
      primed_q     <= 1'b1;
    end
  end

  assign bus.frame_done = frame_done_q;
  assign bus.frame_cnt  = frame_cnt_q;
  assign bus.len_last   = len_last_q;
  assign bus.err_pulse  = err_pulse_q;
  assign bus.err_code   = err_code_q;

`ifdef FWM_STICKY_EN
  logic [4:0] sticky_q, sticky_d;
  logic [4:0] sticky_set;

  // Set is OR-ed in after the clear so a same-cycle error survives.
  always_comb begin
    sticky_set = 5'd0;
    if (err_pulse_d) sticky_set = 5'b00001 << 3'(err_code_d - 3'd1);
    sticky_d = (bus.err_clr ? 5'd0 : sticky_q) | sticky_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= 5'd0;
    else        sticky_q <= sticky_d;
  end

  assign bus.err_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_frame_window_monitor.sv
// Scoreboard bench: stimulus pushes hand-computed expected events, a negedge monitor pops
// and compares whenever frame_done or err_pulse is presented.
module tb_frame_window_monitor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  frame_window_monitor_if #(.LEN_W(4), .CNT_W(16)) bus ();

  frame_window_monitor #(.LEN_W(4), .CNT_W(16), .MIN_LEN(7), .MAX_LEN(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          kind;   // 1 frame_done, 2 err_pulse
    logic [2:0]  code;
    logic [15:0] cnt;
    logic [3:0]  len;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc_n = 0;
  int   ev_n  = 0;
  bit   tg    = 1'b0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    if (rst_n && (bus.frame_done || bus.err_pulse)) begin
      int   k;
      exp_t e;
      k = (bus.frame_done ? 1 : 0) + (bus.err_pulse ? 2 : 0);
      tests++;
      ev_n++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL event%0d unexpected: kind=%0d code=%0d cnt=%0d len=%0d cyc=%0d, required none",
                 ev_n, k, bus.err_code, bus.frame_cnt, bus.len_last, cyc_n);
      end else begin
        e = q.pop_front();
        if (k != e.kind || (k == 2 && bus.err_code != e.code) || bus.frame_cnt != e.cnt ||
            bus.len_last != e.len || cyc_n != e.cyc) begin
          fails++;
          $display("FAIL event%0d kind/code/cnt/len/cyc actual %0d/%0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d/%0d",
                   ev_n, k, bus.err_code, bus.frame_cnt, bus.len_last, cyc_n,
                   e.kind, e.code, e.cnt, e.len, e.cyc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc_n);
    $fatal(1);
  end

  function automatic exp_t mk(input int kind, input int code, input int cnt, input int len);
    exp_t e;
    e.kind = kind;
    e.code = 3'(code);
    e.cnt  = 16'(cnt);
    e.len  = 4'(len);
    e.cyc  = 0;
    return e;
  endfunction

  task automatic push(input exp_t e);
    exp_t t;
    t = e;
    t.cyc = cyc_n;
    q.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic cyc(input bit w, input bit t);
    bus.win_in = w;
    bus.tog_in = t;
    @(posedge clk);
    #1;
  endtask

  // len high samples; optional toggle at window sample tog_at; toggle on fall if tf.
  task automatic frame(input int len, input int tog_at, input bit tf,
                       input int mid_at, input exp_t mid, input exp_t cls);
    for (int i = 1; i <= len; i++) begin
      if (i == tog_at) tg = ~tg;
      cyc(1'b1, tg);
      if (i == mid_at) push(mid);
    end
    if (tf) tg = ~tg;
    cyc(1'b0, tg);
    if (cls.kind != 0) push(cls);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_done"}, 32'(bus.frame_done), 32'd0);
    chk({tag, "_cnt"},  32'(bus.frame_cnt),  32'd0);
    chk({tag, "_len"},  32'(bus.len_last),   32'd0);
    chk({tag, "_err"},  32'(bus.err_pulse),  32'd0);
    chk({tag, "_code"}, 32'(bus.err_code),   32'd0);
`ifdef FWM_STICKY_EN
    chk({tag, "_sticky"}, 32'(bus.err_sticky), 32'd0);
`endif
  endtask

  exp_t none;

  initial begin
    none = mk(0, 0, 0, 0);
    bus.win_in = 1'b0;
    bus.tog_in = 1'b0;
`ifdef FWM_STICKY_EN
    bus.err_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1'b0, tg);

    // Nominal: three back-to-back frames with a single low cycle between them.
    frame(7, 0, 1'b1, 0, none, mk(1, 0, 1, 7));
    frame(7, 0, 1'b1, 0, none, mk(1, 0, 2, 7));
    frame(7, 0, 1'b1, 0, none, mk(1, 0, 3, 7));
    cyc(1'b0, tg);

    // Short window.
    frame(5, 0, 1'b1, 0, none, mk(2, 1, 3, 5));
    cyc(1'b0, tg);
    cyc(1'b0, tg);

    // Long window: error after the 8th high sample, silent close, then a good frame.
    frame(12, 0, 1'b1, 8, mk(2, 2, 3, 5), none);
    @(negedge clk);
    chk("long_len_last", 32'(bus.len_last), 32'd12);
    chk("long_no_err", 32'(bus.err_pulse), 32'd0);
    #6;
    frame(7, 0, 1'b1, 0, none, mk(1, 0, 4, 7));
    cyc(1'b0, tg);

    // Orphan toggle, early toggle at window cycle 3, fall without toggle.
    tg = ~tg;
    cyc(1'b0, tg);
    push(mk(2, 4, 4, 7));
    cyc(1'b0, tg);
    frame(7, 3, 1'b1, 3, mk(2, 5, 4, 7), mk(1, 0, 5, 7));
    cyc(1'b0, tg);
    frame(7, 0, 1'b0, 0, none, mk(2, 3, 5, 7));
    cyc(1'b0, tg);
    cyc(1'b0, tg);
    chk("pre_reset_tog_high", 32'(tg), 32'd1);

    // Reset mid-window with both inputs high; the held window must not count.
    cyc(1'b1, tg);
    cyc(1'b1, tg);
    cyc(1'b1, tg);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1'b1, tg);
    cyc(1'b1, tg);
    cyc(1'b1, tg);
    cyc(1'b0, tg);
    @(negedge clk);
    chk("held_win_no_err", 32'(bus.err_pulse), 32'd0);
    chk("held_win_cnt", 32'(bus.frame_cnt), 32'd0);
    #6;
    cyc(1'b0, tg);
    frame(7, 0, 1'b1, 0, none, mk(1, 0, 1, 7));
    cyc(1'b0, tg);

`ifdef FWM_STICKY_EN
    // Orphan then short accumulate; clear coinciding with a new error keeps that bit.
    tg = ~tg;
    cyc(1'b0, tg);
    push(mk(2, 4, 1, 7));
    cyc(1'b0, tg);
    frame(5, 0, 1'b1, 0, none, mk(2, 1, 1, 5));
    cyc(1'b0, tg);
    chk("sticky_accum", 32'(bus.err_sticky), 32'h09);
    bus.err_clr = 1'b1;
    tg = ~tg;
    cyc(1'b0, tg);
    push(mk(2, 4, 1, 5));
    bus.err_clr = 1'b0;
    chk("sticky_set_wins", 32'(bus.err_sticky), 32'h08);
    bus.err_clr = 1'b1;
    cyc(1'b0, tg);
    bus.err_clr = 1'b0;
    chk("sticky_cleared", 32'(bus.err_sticky), 32'h00);
`endif

    repeat (3) cyc(1'b0, tg);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
